sr_drive_controller: RTL

Command sequencer that sits directly upstream of the NOR-based SR flip-flop and generates its S/R drive. It accepts SET/RESET/TOGGLE/HOLD commands over a valid/ready handshake and guarantees S and R are never high together. It holds the active input for a programmable pulse width, then confirms the flip-flop's Q/Qn feedback through a 2-flop synchroniser. Each command ends with either a one-cycle done pulse or a one-cycle err pulse with a cause code.

---
 rtl/sr_drive_controller.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/sr_drive_controller.sv
// sr_drive_controller
// Command sequencer driving the S/R inputs of a NOR SR flip-flop. Accepts
// HOLD/SET/RESET/TOGGLE over valid/ready, pulses the selected input for
// PULSE_CYC cycles, idles one gap cycle, then confirms the synchronised Q/Qn
// feedback. Each command ends in a one-cycle done or err pulse.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | S=R=0, cmd_ready=1, waiting for a command
// ST_DRIVE | S=target / R=~target held for PULSE_CYC cycles
// ST_GAP   | S=R=0 for one cycle so the flip-flop settles before checking
// ST_CHECK | S=R=0, compare feedback: match > illegal > timeout

module sr_drive_controller #(
  parameter int PULSE_CYC   = 2,
  parameter int TIMEOUT_CYC = 8,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  input  logic       q_fb,
  input  logic       qn_fb,
  output logic       S,
  output logic       R,
  output logic       q_expected,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam logic [1:0] CMD_HOLD   = 2'b00;
  localparam logic [1:0] CMD_SET    = 2'b01;
  localparam logic [1:0] CMD_RESET  = 2'b10;
  localparam logic [1:0] CMD_TOGGLE = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

  // Last counter value of each timed phase; the phase exits on that cycle.
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             target_q, target_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic q_meta_q, q_meta_d;
  logic q_s_q, q_s_d;
  logic qn_meta_q, qn_meta_d;
  logic qn_s_q, qn_s_d;

  logic accept;
  logic fb_match;
  logic fb_illegal;

  // Two-stage synchroniser inputs for the asynchronous flip-flop feedback.
  always_comb begin
    q_meta_d  = q_fb;
    q_s_d     = q_meta_q;
    qn_meta_d = qn_fb;
    qn_s_d    = qn_meta_q;
  end

  // Synchroniser flops; reset to the flip-flop's cleared state (Q=0, Qn=1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_meta_q  <= 1'b0;
      q_s_q     <= 1'b0;
      qn_meta_q <= 1'b1;
      qn_s_q    <= 1'b1;
    end else begin
      q_meta_q  <= q_meta_d;
      q_s_q     <= q_s_d;
      qn_meta_q <= qn_meta_d;
      qn_s_q    <= qn_s_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign fb_match   = (q_s_q == target_q) && (qn_s_q == ~target_q);
  assign fb_illegal = (q_s_q == qn_s_q);

  // Next-state, counter, target and completion logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          err_code_d = ERR_NONE;
          cnt_d      = '0;
          case (cmd)
            CMD_SET:    target_d = 1'b1;
            CMD_RESET:  target_d = 1'b0;
            CMD_TOGGLE: target_d = ~q_s_q;
            default:    target_d = q_s_q;
          endcase
          // HOLD needs no drive and no feedback check: complete immediately.
          if (cmd == CMD_HOLD) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_DRIVE;
          end
        end
      end

      ST_DRIVE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_GAP: begin
        state_d = ST_CHECK;
        cnt_d   = '0;
      end

      ST_CHECK: begin
        if (fb_match) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (fb_illegal) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          err_code_d = ERR_ILLEGAL;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Drive outputs follow the next state so S/R are registered and aligned with
  // DRIVE; deriving both from one target bit keeps S and R mutually exclusive.
  always_comb begin
    s_d = (state_d == ST_DRIVE) &&  target_d;
    r_d = (state_d == ST_DRIVE) && ~target_d;
  end

  // Controller state register; reset forces S=R=0 asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      target_q   <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      s_q        <= s_d;
      r_q        <= r_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign S          = s_q;
  assign R          = r_q;
  assign q_expected = target_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule
